canvas_write_sequencer: RTL and testbench

- Sole owner of the canvas framebuffer write port; the VGA scan path reads the stored 3-bit color codes on a separate read port.
- Two requesters share the write port:
  - Brush-stamp requests: square of (size+1)x(size+1) pixels in one color code.
  - Full-canvas clear: every location written with the erase code.
- Sequences each request into one framebuffer write per clock and arbitrates between the two requesters.

---
 rtl/canvas_write_sequencer.sv | 165 ++++++++++++++++
 tb/tb_canvas_write_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_write_sequencer.sv
// Sole writer of the canvas framebuffer: sequences brush stamps and full-canvas clears
// into one registered write per clock, with clear taking priority over new stamps.
module canvas_write_sequencer #(
  parameter int unsigned CANVAS_W   = 160,
  parameter int unsigned CANVAS_H   = 120,
  parameter int unsigned X_W        = 8,
  parameter int unsigned Y_W        = 7,
  parameter int unsigned ADDR_W     = 15,
  parameter logic [2:0]  ERASE_CODE = 3'd6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              paint_valid,
  output logic              paint_ready,
  input  logic [X_W-1:0]    paint_x,
  input  logic [Y_W-1:0]    paint_y,
  input  logic [2:0]        paint_color,
  input  logic [1:0]        paint_size,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_wdata
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(CANVAS_W * CANVAS_H - 1);
  localparam logic [X_W:0]      XLimit   = (X_W + 1)'(CANVAS_W);
  localparam logic [Y_W:0]      YLimit   = (Y_W + 1)'(CANVAS_H);

  typedef enum logic [1:0] {StIdle, StPaint, StClear} state_e;

  state_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic [X_W-1:0]      px_q, px_d;
  logic [Y_W-1:0]      py_q, py_d;
  logic [2:0]          color_q, color_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          dx_q, dx_d;
  logic [1:0]          dy_q, dy_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          wdata_q, wdata_d;
  logic                done_q, done_d;

  // One extra bit on each sum so stamps near the far edge clip instead of wrapping.
  logic [X_W:0]        sum_x;
  logic [Y_W:0]        sum_y;
  logic                in_bounds;
  logic [ADDR_W-1:0]   pix_addr;

  assign sum_x     = {1'b0, px_q} + (X_W + 1)'(dx_q);
  assign sum_y     = {1'b0, py_q} + (Y_W + 1)'(dy_q);
  assign in_bounds = (sum_x < XLimit) && (sum_y < YLimit);
  assign pix_addr  = ADDR_W'(sum_y) * ADDR_W'(CANVAS_W) + ADDR_W'(sum_x);

  assign busy        = (state_q != StIdle);
  assign paint_ready = (state_q == StIdle) & ~clear_req & ~pending_q;
  assign fb_we       = we_q;
  assign fb_addr     = addr_q;
  assign fb_wdata    = wdata_q;
  assign clear_done  = done_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    px_d      = px_q;
    py_d      = py_q;
    color_d   = color_q;
    size_d    = size_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clear_req || pending_q) begin
          state_d   = StClear;
          pending_d = 1'b0;
          cnt_d     = '0;
        end else if (paint_valid) begin
          state_d = StPaint;
          px_d    = paint_x;
          py_d    = paint_y;
          color_d = paint_color;
          size_d  = paint_size;
          dx_d    = 2'd0;
          dy_d    = 2'd0;
        end
      end
      StPaint: begin
        if (clear_req) pending_d = 1'b1;
        we_d    = in_bounds;
        addr_d  = pix_addr;
        wdata_d = color_q;
        if (dx_q == size_q) begin
          dx_d = 2'd0;
          if (dy_q == size_q) begin
            // A clear queued during the stamp starts straight away, no idle gap.
            if (pending_q || clear_req) begin
              state_d   = StClear;
              pending_d = 1'b0;
              cnt_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            dy_d = dy_q + 2'd1;
          end
        end else begin
          dx_d = dx_q + 2'd1;
        end
      end
      StClear: begin
        we_d    = 1'b1;
        addr_d  = cnt_q;
        wdata_d = ERASE_CODE;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == LastAddr) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      color_q   <= '0;
      size_q    <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      px_q      <= px_d;
      py_q      <= py_d;
      color_q   <= color_d;
      size_q    <= size_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_canvas_write_sequencer.sv
// Directed bench for canvas_write_sequencer: table of stamps with hand-computed write sets,
// plus hand-written clear, collision and mid-clear reset sequences.
`timescale 1ns/1ps
module tb_canvas_write_sequencer;

  localparam int NPix = 160 * 120;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        paint_valid;
  logic        paint_ready;
  logic [7:0]  paint_x;
  logic [6:0]  paint_y;
  logic [2:0]  paint_color;
  logic [1:0]  paint_size;
  logic        clear_req;
  logic        busy;
  logic        clear_done;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] size;
    logic [2:0] color;
    int         nw;
    int         first;
    int         last;
    int         sum;
  } stamp_t;

  stamp_t tab[7];

  canvas_write_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .paint_valid (paint_valid),
    .paint_ready (paint_ready),
    .paint_x     (paint_x),
    .paint_y     (paint_y),
    .paint_color (paint_color),
    .paint_size  (paint_size),
    .clear_req   (clear_req),
    .busy        (busy),
    .clear_done  (clear_done),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_wdata    (fb_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_stamp(input stamp_t v);
    paint_valid = 1'b1;
    paint_x     = v.x;
    paint_y     = v.y;
    paint_size  = v.size;
    paint_color = v.color;
  endtask

  // Called at the first sample after the accepting edge; walks the (size+1)^2 pixel cycles.
  task automatic collect_stamp(input stamp_t v, input bit end_idle, input int clr_at,
                               input string tag);
    int n, nw, sum, first, last, bad;
    n = (int'(v.size) + 1) * (int'(v.size) + 1);
    nw = 0; sum = 0; first = -1; last = -1; bad = 0;
    check({tag, "_busy_start"}, 32'(busy), 1);
    check({tag, "_we_start"}, 32'(fb_we), 0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (clr_at >= 0) clear_req = (k == clr_at);
      if (fb_we) begin
        nw++;
        sum += int'(fb_addr);
        if (first < 0) first = int'(fb_addr);
        last = int'(fb_addr);
        if (fb_wdata !== v.color) bad++;
      end
      if (k < n && busy !== 1'b1) bad++;
    end
    clear_req = 1'b0;
    check({tag, "_nwrites"}, nw, v.nw);
    check({tag, "_addrsum"}, sum, v.sum);
    check({tag, "_bad_cycles"}, bad, 0);
    if (v.nw > 0) begin
      check({tag, "_first"}, first, v.first);
      check({tag, "_last"}, last, v.last);
    end
    if (end_idle) begin
      check({tag, "_busy_end"}, 32'(busy), 0);
      check({tag, "_ready_end"}, 32'(paint_ready), 1);
    end else begin
      check({tag, "_busy_end"}, 32'(busy), 1);
    end
  endtask

  task automatic run_stamp(input stamp_t v, input string tag);
    check({tag, "_ready_pre"}, 32'(paint_ready), 1);
    drive_stamp(v);
    @(negedge clk);
    paint_valid = 1'b0;
    collect_stamp(v, 1'b1, -1, tag);
  endtask

  // Called at the negedge before the edge that starts the clear; stops at the clear_done sample.
  task automatic watch_clear(input int pulse_at, input string tag);
    int writes, bad, done_addr, first_k;
    bit prev_busy, seen;
    writes = 0; bad = 0; done_addr = -1; first_k = -1; prev_busy = 0; seen = 0;
    for (int k = 0; k < NPix + 50; k++) begin
      @(negedge clk);
      clear_req = (k == pulse_at);
      if (fb_we) begin
        if (first_k < 0) first_k = k;
        if (int'(fb_addr) != writes || fb_wdata !== 3'd6) bad++;
        writes++;
      end else if (first_k >= 0) begin
        bad++;
      end
      if (clear_done) begin
        done_addr = int'(fb_addr);
        seen = 1;
        break;
      end
      if (paint_ready) bad++;
      prev_busy = busy;
    end
    clear_req = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 1);
    check({tag, "_writes"}, writes, NPix);
    check({tag, "_bad_cycles"}, bad, 0);
    check({tag, "_done_addr"}, done_addr, NPix - 1);
    check({tag, "_busy_before_done"}, 32'(prev_busy), 1);
    check({tag, "_first_write_k"}, first_k, (pulse_at == -2) ? 0 : 1);
  endtask

  initial begin
    stamp_t v;
    int quiet_bad;
    bit found;

    tab[0] = '{x: 8'd10,  y: 7'd20,  size: 2'd1, color: 3'd2, nw: 4, first: 3210,
               last: 3371, sum: 13162};
    tab[1] = '{x: 8'd158, y: 7'd119, size: 2'd3, color: 3'd5, nw: 2, first: 19198,
               last: 19199, sum: 38397};
    tab[2] = '{x: 8'd0,   y: 7'd0,   size: 2'd0, color: 3'd7, nw: 1, first: 0,
               last: 0, sum: 0};
    tab[3] = '{x: 8'd159, y: 7'd0,   size: 2'd2, color: 3'd1, nw: 3, first: 159,
               last: 479, sum: 957};
    tab[4] = '{x: 8'd0,   y: 7'd118, size: 2'd3, color: 3'd4, nw: 8, first: 18880,
               last: 19043, sum: 151692};
    tab[5] = '{x: 8'd200, y: 7'd10,  size: 2'd1, color: 3'd3, nw: 0, first: 0,
               last: 0, sum: 0};
    tab[6] = '{x: 8'd255, y: 7'd127, size: 2'd3, color: 3'd6, nw: 0, first: 0,
               last: 0, sum: 0};

    reset_n = 1'b0; paint_valid = 1'b0; paint_x = '0; paint_y = '0;
    paint_color = '0; paint_size = '0; clear_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(fb_we), 0);
    check("rst_addr", 32'(fb_addr), 0);
    check("rst_wdata", 32'(fb_wdata), 0);
    check("rst_done", 32'(clear_done), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_we", 32'(fb_we), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_ready", 32'(paint_ready), 1);
    end

    for (int i = 0; i < 7; i++) run_stamp(tab[i], $sformatf("stamp%0d", i));

    // Full clear with a stray clear_req mid-way that must be ignored.
    clear_req = 1'b1;
    watch_clear(300, "clear");
    quiet_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || fb_we || clear_done) quiet_bad++;
    end
    check("clear_quiet_after", quiet_bad, 0);

    // Clear and stamp collide in IDLE: clear first, stamp taken right after.
    drive_stamp(tab[0]);
    clear_req = 1'b1;
    #1;
    check("col_ready_low", 32'(paint_ready), 0);
    watch_clear(-1, "col_clear");
    check("col_ready_after", 32'(paint_ready), 1);
    @(negedge clk);
    paint_valid = 1'b0;
    collect_stamp(tab[0], 1'b1, -1, "col_stamp");

    // Clear requested during a 4x4 stamp: stamp finishes, clear follows with no gap.
    v = '{x: 8'd20, y: 7'd30, size: 2'd3, color: 3'd1, nw: 16, first: 4820,
          last: 5303, sum: 80984};
    check("pc_ready_pre", 32'(paint_ready), 1);
    drive_stamp(v);
    @(negedge clk);
    paint_valid = 1'b0;
    collect_stamp(v, 1'b0, 5, "pc_stamp");
    watch_clear(-2, "pc_clear");

    // Reset in the middle of a clear abandons it.
    repeat (2) @(negedge clk);
    clear_req = 1'b1;
    found = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      clear_req = 1'b0;
      if (fb_we && fb_addr == 15'd5000) begin
        found = 1;
        break;
      end
    end
    check("mrst_reached_5000", 32'(found), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mrst_we", 32'(fb_we), 0);
    check("mrst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    quiet_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || fb_we || clear_done || !paint_ready) quiet_bad++;
    end
    check("mrst_not_resumed", quiet_bad, 0);
    run_stamp(tab[0], "mrst_stamp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
